// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control sequencer: FETCH/DECODE/EXEC/MEM/WB
// with memory handshake stalls, retire counting and illegal-op trap.
module mc_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             MemWrite,
  output logic             IorD,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic [1:0]       PCSource,
  output logic             ALUSelA,
  output logic [1:0]       ALUSelB,
  output logic [1:0]       ALUOp,
  output logic             EXTCtr,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             retire,
  output logic [CNT_W-1:0] instr_cnt,
  output logic             trap
);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ORI  = 6'h0D;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD,
    S_MEMWB, S_MEMWR, S_EXEC, S_RWB,
    S_BRANCH, S_JUMP, S_IMMEX, S_IMMWB,
    S_TRAP
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             trap_q;
  logic             func_ok;
  logic             live;
  logic             unused_zero;

  // zero only qualifies PCWriteCond in the datapath
  assign unused_zero = zero;
  assign live        = ~reset;
  assign instr_cnt   = cnt_q;
  assign trap        = trap_q;

  assign func_ok = (func == 6'h20) || (func == 6'h22) ||
                   (func == 6'h24) || (func == 6'h25) ||
                   (func == 6'h2A);

  // State sequencing, retire counter and sticky trap flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      trap_q  <= 1'b0;
    end else begin
      if (retire)
        cnt_q <= cnt_q + CNT_W'(1);
      unique case (state_q)
        S_FETCH:
          if (mem_ready) state_q <= S_DECODE;
        S_DECODE:
          if (op == OP_LW || op == OP_SW)
            state_q <= S_MEMADR;
          else if (op == OP_R)
            state_q <= S_EXEC;
          else if (op == OP_BEQ)
            state_q <= S_BRANCH;
          else if (op == OP_J)
            state_q <= S_JUMP;
          else if (op == OP_ADDI || op == OP_ORI)
            state_q <= S_IMMEX;
          else begin
            state_q <= S_TRAP;
            trap_q  <= 1'b1;
          end
        S_MEMADR:
          state_q <= (op == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:
          if (mem_ready) state_q <= S_MEMWB;
        S_MEMWR:
          if (mem_ready) state_q <= S_FETCH;
        S_EXEC:
          if (func_ok)
            state_q <= S_RWB;
          else begin
            state_q <= S_TRAP;
            trap_q  <= 1'b1;
          end
        S_IMMEX:
          state_q <= S_IMMWB;
        S_TRAP:
          state_q <= S_TRAP;
        default:
          state_q <= S_FETCH;
      endcase
    end
  end

  // Moore strobe decode; handshake strobes drop while reset is high
  always_comb begin
    mem_req     = 1'b0;
    MemWrite    = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 2'd0;
    ALUSelA     = 1'b0;
    ALUSelB     = 2'd0;
    ALUOp       = 2'd0;
    EXTCtr      = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    retire      = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_req = live;
        ALUSelB = 2'd1;
        IRWrite = mem_ready & live;
        PCWrite = mem_ready & live;
      end
      S_DECODE:
        ALUSelB = 2'd3;
      S_MEMADR: begin
        ALUSelA = 1'b1;
        ALUSelB = 2'd2;
      end
      S_MEMRD: begin
        mem_req = live;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        retire   = live;
      end
      S_MEMWR: begin
        mem_req  = live;
        IorD     = 1'b1;
        MemWrite = live;
        retire   = mem_ready & live;
      end
      S_EXEC: begin
        ALUSelA = 1'b1;
        ALUOp   = 2'd2;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        retire   = live;
      end
      S_BRANCH: begin
        ALUSelA     = 1'b1;
        ALUOp       = 2'd1;
        PCWriteCond = 1'b1;
        PCSource    = 2'd1;
        retire      = live;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'd2;
        retire   = live;
      end
      S_IMMEX: begin
        ALUSelA = 1'b1;
        ALUSelB = 2'd2;
        if (op == OP_ORI) begin
          ALUOp  = 2'd3;
          EXTCtr = 1'b1;
        end
      end
      S_IMMWB: begin
        RegWrite = 1'b1;
        retire   = live;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: per-instruction cycle
// expectations queued by stimulus, popped by a negedge monitor.
module tb_mc_control_fsm;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       alu_sel_a;
    logic [1:0] alu_sel_b;
    logic [1:0] alu_op;
    logic       ext_ctr;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       retire;
    logic       trap;
  } ctl_t;

  typedef struct {
    ctl_t        c;
    logic [31:0] cnt;
    logic        chk;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] op = '0;
  logic [5:0] func = '0;
  logic zero = 1'b0;
  logic mem_ready = 1'b0;

  logic mem_req, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond;
  logic [1:0] PCSource, ALUSelB, ALUOp;
  logic ALUSelA, EXTCtr, RegWrite, RegDst, MemtoReg, retire, trap;
  logic [31:0] instr_cnt;

  logic s_mem_req, s_MemWrite, s_IorD, s_IRWrite, s_PCWrite;
  logic s_PCWriteCond, s_ALUSelA, s_EXTCtr, s_RegWrite, s_RegDst;
  logic s_MemtoReg, s_retire, s_trap;
  logic [1:0] s_PCSource, s_ALUSelB, s_ALUOp;
  logic [2:0] s_instr_cnt;

  ctl_t act, s_act;
  exp_t q[$];
  logic [31:0] cnt = '0;
  int n_chk = 0;
  int n_pass = 0;
  int cyc_no = 0;

  always #5 clk = ~clk;

  mc_control_fsm #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .op(op), .func(func),
    .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .MemWrite(MemWrite), .IorD(IorD),
    .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .PCSource(PCSource),
    .ALUSelA(ALUSelA), .ALUSelB(ALUSelB), .ALUOp(ALUOp),
    .EXTCtr(EXTCtr), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .retire(retire),
    .instr_cnt(instr_cnt), .trap(trap)
  );

  mc_control_fsm #(.CNT_W(3)) u_small (
    .clk(clk), .reset(reset), .op(op), .func(func),
    .zero(zero), .mem_ready(mem_ready),
    .mem_req(s_mem_req), .MemWrite(s_MemWrite), .IorD(s_IorD),
    .IRWrite(s_IRWrite), .PCWrite(s_PCWrite),
    .PCWriteCond(s_PCWriteCond), .PCSource(s_PCSource),
    .ALUSelA(s_ALUSelA), .ALUSelB(s_ALUSelB), .ALUOp(s_ALUOp),
    .EXTCtr(s_EXTCtr), .RegWrite(s_RegWrite), .RegDst(s_RegDst),
    .MemtoReg(s_MemtoReg), .retire(s_retire),
    .instr_cnt(s_instr_cnt), .trap(s_trap)
  );

  assign act = {mem_req, MemWrite, IorD, IRWrite, PCWrite,
                PCWriteCond, PCSource, ALUSelA, ALUSelB, ALUOp,
                EXTCtr, RegWrite, RegDst, MemtoReg, retire, trap};
  assign s_act = {s_mem_req, s_MemWrite, s_IorD, s_IRWrite,
                  s_PCWrite, s_PCWriteCond, s_PCSource, s_ALUSelA,
                  s_ALUSelB, s_ALUOp, s_EXTCtr, s_RegWrite,
                  s_RegDst, s_MemtoReg, s_retire, s_trap};

  // monitor: pop one expectation per cycle, compare mid-cycle
  always @(negedge clk) begin
    exp_t e;
    cyc_no++;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.chk) begin
        n_chk++;
        if (act === e.c) n_pass++;
        else $display("FAIL ctl cyc=%0d act=%h exp=%h",
                      cyc_no, act, e.c);
        n_chk++;
        if (instr_cnt === e.cnt) n_pass++;
        else $display("FAIL instr_cnt cyc=%0d act=%0d exp=%0d",
                      cyc_no, instr_cnt, e.cnt);
        n_chk++;
        if (s_act === e.c && s_instr_cnt === e.cnt[2:0]) n_pass++;
        else $display("FAIL small cyc=%0d act=%h/%0d exp=%h/%0d",
                      cyc_no, s_act, s_instr_cnt, e.c, e.cnt[2:0]);
      end
    end
  end

  task automatic cyc(input ctl_t e, input logic mr);
    @(posedge clk);
    #1;
    reset = 1'b0;
    mem_ready = mr;
    zero = 1'($urandom);
    q.push_back('{c: e, cnt: cnt, chk: 1'b1});
    if (e.retire) cnt = cnt + 32'd1;
  endtask

  task automatic rst_cyc();
    @(posedge clk);
    #1;
    reset = 1'b1;
    mem_ready = 1'($urandom);
    q.push_back('{c: '0, cnt: cnt, chk: 1'b0});
    cnt = '0;
  endtask

  function automatic logic legal_op(input logic [5:0] o);
    return o inside {6'h00, 6'h23, 6'h2B, 6'h04,
                     6'h02, 6'h08, 6'h0D};
  endfunction

  function automatic logic legal_func(input logic [5:0] f);
    return f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  endfunction

  task automatic do_fetch(input int fst);
    ctl_t c;
    for (int i = 0; i <= fst; i++) begin
      op = 6'($urandom);
      func = 6'($urandom);
      c = '0;
      c.mem_req = 1'b1;
      c.alu_sel_b = 2'd1;
      c.ir_write = (i == fst);
      c.pc_write = (i == fst);
      cyc(c, i == fst);
    end
  endtask

  task automatic do_decode(input logic [5:0] o, input logic [5:0] f);
    ctl_t c;
    op = o;
    func = f;
    c = '0;
    c.alu_sel_b = 2'd3;
    cyc(c, 1'($urandom));
  endtask

  task automatic trap_tail();
    ctl_t c;
    c = '0;
    c.trap = 1'b1;
    repeat (12) cyc(c, 1'($urandom));
    rst_cyc();
  endtask

  // one instruction: fetch stalls, then memory stalls if any
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                           input int fst, input int mst);
    ctl_t c;
    do_fetch(fst);
    do_decode(o, f);
    c = '0;
    if (o == 6'h23 || o == 6'h2B) begin
      c.alu_sel_a = 1'b1;
      c.alu_sel_b = 2'd2;
      cyc(c, 1'($urandom));
      c = '0;
      c.mem_req = 1'b1;
      c.iord = 1'b1;
      c.mem_write = (o == 6'h2B);
      for (int i = 0; i <= mst; i++) begin
        c.retire = (o == 6'h2B) && (i == mst);
        cyc(c, i == mst);
      end
      if (o == 6'h23) begin
        c = '0;
        c.reg_write = 1'b1;
        c.mem_to_reg = 1'b1;
        c.retire = 1'b1;
        cyc(c, 1'($urandom));
      end
    end else if (o == 6'h00) begin
      c.alu_sel_a = 1'b1;
      c.alu_op = 2'd2;
      cyc(c, 1'($urandom));
      if (legal_func(f)) begin
        c = '0;
        c.reg_write = 1'b1;
        c.reg_dst = 1'b1;
        c.retire = 1'b1;
        cyc(c, 1'($urandom));
      end else trap_tail();
    end else if (o == 6'h04) begin
      c.alu_sel_a = 1'b1;
      c.alu_op = 2'd1;
      c.pc_write_cond = 1'b1;
      c.pc_source = 2'd1;
      c.retire = 1'b1;
      cyc(c, 1'($urandom));
    end else if (o == 6'h02) begin
      c.pc_write = 1'b1;
      c.pc_source = 2'd2;
      c.retire = 1'b1;
      cyc(c, 1'($urandom));
    end else if (o == 6'h08 || o == 6'h0D) begin
      c.alu_sel_a = 1'b1;
      c.alu_sel_b = 2'd2;
      c.alu_op = (o == 6'h0D) ? 2'd3 : 2'd0;
      c.ext_ctr = (o == 6'h0D);
      cyc(c, 1'($urandom));
      c = '0;
      c.reg_write = 1'b1;
      c.retire = 1'b1;
      cyc(c, 1'($urandom));
    end else begin
      trap_tail();
    end
  endtask

  // sw stalled in its write, then reset mid-access
  task automatic sw_abort(input int mst);
    ctl_t c;
    do_fetch(0);
    do_decode(6'h2B, 6'($urandom));
    c = '0;
    c.alu_sel_a = 1'b1;
    c.alu_sel_b = 2'd2;
    cyc(c, 1'($urandom));
    c = '0;
    c.mem_req = 1'b1;
    c.iord = 1'b1;
    c.mem_write = 1'b1;
    for (int i = 0; i <= mst; i++) cyc(c, 1'b0);
    rst_cyc();
  endtask

  logic [5:0] rf[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

  initial begin
    logic [5:0] o, f;
    int k;
    rst_cyc();
    rst_cyc();
    run_instr(6'h00, 6'h20, 0, 0);
    run_instr(6'h23, 6'h00, 0, 2);
    run_instr(6'h04, 6'h00, 1, 0);
    run_instr(6'h04, 6'h00, 0, 0);
    run_instr(6'h0D, 6'h00, 0, 0);
    run_instr(6'h08, 6'h00, 2, 0);
    run_instr(6'h2B, 6'h00, 0, 1);
    for (int i = 0; i < 9; i++) run_instr(6'h02, 6'h00, 0, 0);
    run_instr(6'h3F, 6'h00, 0, 0);
    run_instr(6'h02, 6'h00, 0, 0);
    sw_abort(1);
    run_instr(6'h02, 6'h00, 0, 0);
    for (int n = 0; n < 400; n++) begin
      k = $urandom_range(0, 99);
      f = rf[$urandom_range(0, 4)];
      if (k < 15) o = 6'h00;
      else if (k < 27) o = 6'h23;
      else if (k < 39) o = 6'h2B;
      else if (k < 51) o = 6'h04;
      else if (k < 63) o = 6'h02;
      else if (k < 75) o = 6'h08;
      else if (k < 87) o = 6'h0D;
      else if (k < 91) begin
        o = 6'h00;
        do f = 6'($urandom); while (legal_func(f));
      end else if (k < 94) begin
        do o = 6'($urandom); while (legal_op(o));
      end else o = 6'h3F;
      if (k >= 97) sw_abort($urandom_range(0, 2));
      else run_instr(o, f, $urandom_range(0, 2),
                     $urandom_range(0, 3));
    end
    repeat (3) @(posedge clk);
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain left=%0d exp=0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
